// File: rtl/cart_bank_mapper.sv
// Cartridge bank mapper: /TIME bank register file, CPU->ROM/SRAM address translation,
// ROM request/acknowledge FSM and self-generated DTACK_N. Define CART_BANK_TIMEOUT_EN for the ROM watchdog.
module cart_bank_mapper #(
    parameter int NUM_BANKS = 8,
    parameter int BANK_W    = 6,
    parameter int WIN_W     = 19,
    parameter int TIMEOUT   = 255
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [23:1]              VA,
    input  logic [15:0]              VDI,
    output logic [15:0]              VDO,
    input  logic                     AS_N,
    input  logic                     LWR_N,
    input  logic                     UWR_N,
    input  logic                     CE0_N,
    input  logic                     TIME_N,
    output logic                     DTACK_N,
    output logic [BANK_W+WIN_W-1:1]  ROM_A,
    output logic                     ROM_RD,
    input  logic                     ROM_ACK,
    input  logic [15:0]              ROM_DI,
    output logic [15:1]              SRAM_A,
    input  logic [7:0]               SRAM_DI,
    output logic [7:0]               SRAM_DO,
    output logic                     SRAM_RD,
    output logic                     SRAM_WR,
    output logic [2:0]               dbg_state
);
    localparam int SEL_W = $clog2(NUM_BANKS);
    localparam int RA_W  = BANK_W + WIN_W - 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ROM_REQ = 3'd1,
        S_SRAM_RD = 3'd2,
        S_ACK     = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    state_t             state;
    logic               as_prev, lwr_prev;
    logic               dly, abort_q;
    logic [2:0]         ctrl_q;
    logic [BANK_W-1:0]  bank_q [NUM_BANKS];
    logic               err_q;

`ifdef CART_BANK_TIMEOUT_EN
    logic [15:0]        wd_cnt;
`else
    assign err_q = 1'b0;
`endif

    logic               as_fall, lwr_fall, is_write, sram_hit, reg_wr;
    logic [SEL_W-1:0]   reg_idx, sel;
    logic [RA_W-1:0]    rom_addr;
    logic [15:0]        reg_rdata;
    logic               unused_vdi_hi;

    assign as_fall   = as_prev & ~AS_N;
    assign lwr_fall  = lwr_prev & ~LWR_N;
    assign is_write  = ~(LWR_N & UWR_N);
    assign reg_idx   = VA[SEL_W:1];
    assign sel       = VA[WIN_W+SEL_W-1:WIN_W];
    assign sram_hit  = ctrl_q[1] & VA[21] & ~CE0_N;
    assign reg_wr    = ~TIME_N & lwr_fall;
    assign rom_addr  = ctrl_q[0] ? {bank_q[sel], VA[WIN_W-1:1]} : RA_W'(VA);
    assign reg_rdata = (reg_idx == '0) ? {err_q, 12'b0, ctrl_q} : 16'(bank_q[reg_idx]);
    assign dbg_state = state;
    assign unused_vdi_hi = &{1'b0, VDI[15:8]};

    // Register writes are independent of the bus FSM so they coexist with a ROM ack.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ctrl_q <= 3'b000;
            for (int k = 0; k < NUM_BANKS; k++) bank_q[k] <= BANK_W'(k);
        end else if (reg_wr) begin
            if (reg_idx == '0) ctrl_q <= VDI[2:0];
            else               bank_q[reg_idx] <= VDI[BANK_W-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            as_prev  <= 1'b1;
            lwr_prev <= 1'b1;
            VDO      <= 16'h0000;
            DTACK_N  <= 1'b1;
            ROM_A    <= '0;
            ROM_RD   <= 1'b0;
            SRAM_A   <= '0;
            SRAM_DO  <= 8'h00;
            SRAM_RD  <= 1'b0;
            SRAM_WR  <= 1'b0;
            dly      <= 1'b0;
            abort_q  <= 1'b0;
`ifdef CART_BANK_TIMEOUT_EN
            err_q    <= 1'b0;
            wd_cnt   <= 16'd0;
`endif
        end else begin
            as_prev  <= AS_N;
            lwr_prev <= LWR_N;
            SRAM_RD  <= 1'b0;
            SRAM_WR  <= 1'b0;
            case (state)
                S_IDLE: if (as_fall) begin
                    if (!TIME_N) begin
                        if (!is_write) VDO <= reg_rdata;
                        dly   <= 1'b1;
                        state <= S_ACK;
                    end else if (sram_hit) begin
                        SRAM_A <= VA[15:1];
                        dly    <= 1'b1;
                        if (is_write) begin
                            if (!ctrl_q[2]) begin
                                SRAM_WR <= 1'b1;
                                SRAM_DO <= VDI[7:0];
                            end
                            state <= S_ACK;
                        end else begin
                            SRAM_RD <= 1'b1;
                            state   <= S_SRAM_RD;
                        end
                    end else if (!CE0_N) begin
                        if (is_write) begin
                            dly   <= 1'b1;
                            state <= S_ACK;
                        end else begin
                            ROM_A   <= rom_addr;
                            ROM_RD  <= 1'b1;
                            dly     <= 1'b0;
                            abort_q <= 1'b0;
`ifdef CART_BANK_TIMEOUT_EN
                            wd_cnt  <= 16'd0;
`endif
                            state   <= S_ROM_REQ;
                        end
                    end
                end
                // The ROM side cannot cancel; an abandoned cycle still waits for ack/timeout.
                S_ROM_REQ: begin
                    if (AS_N) abort_q <= 1'b1;
                    if (ROM_ACK) begin
                        ROM_RD <= 1'b0;
                        if (abort_q || AS_N) state <= S_IDLE;
                        else begin
                            VDO   <= ROM_DI;
                            state <= S_ACK;
                        end
                    end
`ifdef CART_BANK_TIMEOUT_EN
                    else if (wd_cnt == 16'(TIMEOUT - 1)) begin
                        ROM_RD <= 1'b0;
                        err_q  <= 1'b1;
                        if (abort_q || AS_N) state <= S_IDLE;
                        else begin
                            VDO   <= 16'hFFFF;
                            state <= S_ACK;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end
                S_SRAM_RD: begin
                    if (dly) dly <= 1'b0;
                    else begin
                        VDO   <= {8'hFF, SRAM_DI};
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (dly) dly <= 1'b0;
                    else begin
                        DTACK_N <= 1'b0;
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: if (AS_N) begin
                    DTACK_N <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cart_bank_mapper.sv
// Directed bench for cart_bank_mapper: table of bus accesses plus abort, timeout and reset sequences.
module tb_cart_bank_mapper;
    logic        clk, rst_n;
    logic [23:1] va;
    logic [15:0] vdi, vdo;
    logic        as_n, lwr_n, uwr_n, ce0_n, time_n, dtack_n;
    logic [24:1] rom_a;
    logic        rom_rd, rom_ack;
    logic [15:0] rom_di;
    logic [15:1] sram_a;
    logic [7:0]  sram_di, sram_do;
    logic        sram_rd, sram_wr;
    logic [2:0]  dbg_state;

    cart_bank_mapper dut (
        .CLK(clk), .RST_N(rst_n), .VA(va), .VDI(vdi), .VDO(vdo),
        .AS_N(as_n), .LWR_N(lwr_n), .UWR_N(uwr_n), .CE0_N(ce0_n), .TIME_N(time_n),
        .DTACK_N(dtack_n), .ROM_A(rom_a), .ROM_RD(rom_rd), .ROM_ACK(rom_ack), .ROM_DI(rom_di),
        .SRAM_A(sram_a), .SRAM_DI(sram_di), .SRAM_DO(sram_do), .SRAM_RD(sram_rd),
        .SRAM_WR(sram_wr), .dbg_state(dbg_state)
    );

    typedef struct {
        string       name;
        logic [23:0] addr;
        logic        wr;
        logic        time_acc;
        logic        ce0;
        logic [15:0] data;
        int          exp_lat;
        logic        chk_vdo;
        logic [15:0] exp_vdo;
        logic        exp_rom_rd;
        logic [23:0] exp_rom_a;
        logic        exp_sram_wr;
        logic [7:0]  exp_sram_do;
    } vec_t;

    int total = 0;
    int bad = 0;
    int rom_delay = 4;
    logic rom_resp_en = 1'b1;
    logic [15:0] rom_data = 16'h0000;
    logic cap_rom_rd, cap_sram_wr, cap_end_rom_rd, cap_rel_dtack;
    logic [24:1] cap_rom_a;
    logic [7:0] cap_sram_do;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit got=running exp=finished");
        $fatal(1, "time limit");
    end

    // ROM and SRAM behavioural responders
    initial begin
        int rcnt;
        logic sflag;
        rcnt = 0;
        sflag = 1'b0;
        rom_ack = 1'b0;
        rom_di = 16'h0000;
        sram_di = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            rom_ack = 1'b0;
            if (rom_rd && rom_resp_en) begin
                if (rcnt == rom_delay) begin
                    rom_ack = 1'b1;
                    rom_di = rom_data;
                    rcnt = 0;
                end else rcnt++;
            end else if (!rom_rd) rcnt = 0;
            sram_di = sflag ? 8'h5C : 8'h00;
            sflag = sram_rd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic vec_t mkv(input string name, input logic [23:0] addr, input logic wr,
                                 input logic time_acc, input logic ce0, input logic [15:0] data,
                                 input int exp_lat, input logic chk_vdo, input logic [15:0] exp_vdo,
                                 input logic exp_rom_rd, input logic [23:0] exp_rom_a,
                                 input logic exp_sram_wr, input logic [7:0] exp_sram_do);
        vec_t v;
        v.name = name; v.addr = addr; v.wr = wr; v.time_acc = time_acc; v.ce0 = ce0;
        v.data = data; v.exp_lat = exp_lat; v.chk_vdo = chk_vdo; v.exp_vdo = exp_vdo;
        v.exp_rom_rd = exp_rom_rd; v.exp_rom_a = exp_rom_a;
        v.exp_sram_wr = exp_sram_wr; v.exp_sram_do = exp_sram_do;
        return v;
    endfunction

    task automatic release_bus();
        as_n = 1'b1; lwr_n = 1'b1; uwr_n = 1'b1; ce0_n = 1'b1; time_n = 1'b1;
    endtask

    // driver: one bus cycle; lat = edges from the AS_N edge to DTACK_N low, -1 if never
    task automatic bus_access(input vec_t v, input int budget, output int lat);
        va = v.addr[23:1];
        vdi = v.data;
        rom_data = v.data;
        time_n = ~v.time_acc;
        ce0_n = ~v.ce0;
        lwr_n = ~v.wr;
        uwr_n = ~v.wr;
        as_n = 1'b0;
        tick();
        cap_rom_rd = rom_rd;
        cap_rom_a = rom_a;
        cap_sram_wr = sram_wr;
        cap_sram_do = sram_do;
        lat = 1;
        while (dtack_n && lat < budget) begin
            tick();
            lat++;
        end
        if (dtack_n) lat = -1;
        cap_end_rom_rd = rom_rd;
        release_bus();
        tick();
        cap_rel_dtack = dtack_n;
        tick();
    endtask

    task automatic reg_read(input string name, input int idx, input logic [15:0] exp);
        int lat;
        bus_access(mkv(name, 24'(idx * 2), 1'b0, 1'b1, 1'b0, 16'h0, 3, 1'b1, exp,
                       1'b0, 24'h0, 1'b0, 8'h0), 40, lat);
        check({name, "_lat"}, 32'(lat), 32'd3);
        check(name, 32'(vdo), 32'(exp));
    endtask

    vec_t vecs[14];

    initial begin
        int lat;
        logic dt_seen;

        vecs[0]  = mkv("wr_ctrl_banken", 24'h000000, 1, 1, 0, 16'h0001, 3, 0, 16'h0, 0, 24'h0, 0, 8'h0);
        vecs[1]  = mkv("wr_bank2",       24'h000004, 1, 1, 0, 16'h002A, 3, 0, 16'h0, 0, 24'h0, 0, 8'h0);
        vecs[2]  = mkv("rd_bank2",       24'h000004, 0, 1, 0, 16'h0000, 3, 1, 16'h002A, 0, 24'h0, 0, 8'h0);
        vecs[3]  = mkv("rom_win2",       24'h100000, 0, 0, 1, 16'h1234, 7, 1, 16'h1234, 1, 24'hA80000, 0, 8'h0);
        vecs[4]  = mkv("rom_win5",       24'h2811F6, 0, 0, 1, 16'hBEEF, 7, 1, 16'hBEEF, 1, 24'h1408FB, 0, 8'h0);
        vecs[5]  = mkv("rom_wr_ignored", 24'h100000, 1, 0, 1, 16'h7777, 3, 0, 16'h0, 0, 24'h0, 0, 8'h0);
        vecs[6]  = mkv("unmapped",       24'h100000, 0, 0, 0, 16'h0000, -1, 0, 16'h0, 0, 24'h0, 0, 8'h0);
        vecs[7]  = mkv("wr_ctrl_linear", 24'h000000, 1, 1, 0, 16'h0002, 3, 0, 16'h0, 0, 24'h0, 0, 8'h0);
        vecs[8]  = mkv("rom_linear",     24'h100000, 0, 0, 1, 16'h4321, 7, 1, 16'h4321, 1, 24'h080000, 0, 8'h0);
        vecs[9]  = mkv("sram_wr",        24'h200000, 1, 0, 1, 16'h00AB, 3, 0, 16'h0, 0, 24'h0, 1, 8'hAB);
        vecs[10] = mkv("sram_rd",        24'h200002, 0, 0, 1, 16'h0000, 4, 1, 16'hFF5C, 0, 24'h0, 0, 8'h0);
        vecs[11] = mkv("wr_ctrl_wp",     24'h000000, 1, 1, 0, 16'h0006, 3, 0, 16'h0, 0, 24'h0, 0, 8'h0);
        vecs[12] = mkv("sram_wr_wp",     24'h200000, 1, 0, 1, 16'h00CD, 3, 0, 16'h0, 0, 24'h0, 0, 8'h0);
        vecs[13] = mkv("rd_ctrl",        24'h000000, 0, 1, 0, 16'h0000, 3, 1, 16'h0006, 0, 24'h0, 0, 8'h0);

        rst_n = 1'b0;
        va = '0;
        vdi = 16'h0;
        release_bus();
        tick();
        tick();
        check("rst_dtack_n", 32'(dtack_n), 32'd1);
        check("rst_rom_rd", 32'(rom_rd), 32'd0);
        check("rst_vdo", 32'(vdo), 32'd0);
        check("rst_rom_a", 32'(rom_a), 32'd0);
        check("rst_sram_pulses", 32'({sram_rd, sram_wr}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int k = 1; k < 8; k++) reg_read($sformatf("rst_bank%0d", k), k, 16'(k));
        reg_read("rst_ctrl", 0, 16'h0000);

        for (int i = 0; i < 14; i++) begin
            bus_access(vecs[i], 40, lat);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
            if (vecs[i].chk_vdo) check({vecs[i].name, "_vdo"}, 32'(vdo), 32'(vecs[i].exp_vdo));
            check({vecs[i].name, "_rom_rd"}, 32'(cap_rom_rd), 32'(vecs[i].exp_rom_rd));
            if (vecs[i].exp_rom_rd) check({vecs[i].name, "_rom_a"}, 32'(cap_rom_a), 32'(vecs[i].exp_rom_a));
            check({vecs[i].name, "_sram_wr"}, 32'(cap_sram_wr), 32'(vecs[i].exp_sram_wr));
            if (vecs[i].exp_sram_wr) check({vecs[i].name, "_sram_do"}, 32'(cap_sram_do), 32'(vecs[i].exp_sram_do));
            if (vecs[i].exp_lat > 0) check({vecs[i].name, "_dtack_rel"}, 32'(cap_rel_dtack), 32'd1);
        end

        // AS_N dropped two cycles into ROM_REQ; the late ack must not produce DTACK_N
        rom_delay = 5;
        va = 24'h100000 >> 1;
        ce0_n = 1'b0;
        as_n = 1'b0;
        tick();
        check("abort_rom_rd", 32'(rom_rd), 32'd1);
        tick();
        tick();
        release_bus();
        dt_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (!dtack_n) dt_seen = 1'b1;
        end
        check("abort_no_dtack", 32'(dt_seen), 32'd0);
        check("abort_rom_rd_end", 32'(rom_rd), 32'd0);
        check("abort_vdo", 32'(vdo), 32'h0006);
        check("abort_state", 32'(dbg_state), 32'd0);
        rom_delay = 4;
        bus_access(mkv("after_abort", 24'h100000, 0, 0, 1, 16'h5A5A, 7, 1, 16'h5A5A, 1, 24'h080000, 0, 8'h0), 40, lat);
        check("after_abort_lat", 32'(lat), 32'd7);
        check("after_abort_vdo", 32'(vdo), 32'h5A5A);

`ifdef CART_BANK_TIMEOUT_EN
        rom_resp_en = 1'b0;
        bus_access(mkv("timeout", 24'h100000, 0, 0, 1, 16'h0000, 257, 1, 16'hFFFF, 1, 24'h080000, 0, 8'h0), 300, lat);
        rom_resp_en = 1'b1;
        check("timeout_lat", 32'(lat), 32'd257);
        check("timeout_rom_rd", 32'(cap_end_rom_rd), 32'd0);
        check("timeout_vdo", 32'(vdo), 32'hFFFF);
        reg_read("timeout_err", 0, 16'h8006);
`else
        reg_read("no_err_bit", 0, 16'h0006);
`endif

        // asynchronous reset in the middle of a ROM request
        bus_access(mkv("wr_bank3", 24'h000006, 1, 1, 0, 16'h0011, 3, 0, 16'h0, 0, 24'h0, 0, 8'h0), 40, lat);
        reg_read("rd_bank3", 3, 16'h0011);
        rom_resp_en = 1'b0;
        va = 24'h100000 >> 1;
        ce0_n = 1'b0;
        as_n = 1'b0;
        tick();
        check("rstmid_rom_rd", 32'(rom_rd), 32'd1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_rom_rd_clr", 32'(rom_rd), 32'd0);
        check("rstmid_dtack_n", 32'(dtack_n), 32'd1);
        check("rstmid_rom_a", 32'(rom_a), 32'd0);
        check("rstmid_state", 32'(dbg_state), 32'd0);
        release_bus();
        tick();
        rst_n = 1'b1;
        tick();
        rom_resp_en = 1'b1;
        reg_read("rstmid_bank3", 3, 16'h0003);
        reg_read("rstmid_ctrl", 0, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
